memory_access_unit: RTL and testbench

- Parametrised successor to the MEM pipeline stage: performs loads/stores over a variable-latency request/acknowledge data bus instead of a fixed single-cycle RAM.
- Supports 32- or 64-bit datapaths and byte/half/word/double accesses, with sign or zero extension on loads.
- Misaligned accesses are either split into two bus beats or trapped, selected by parameter.
- Stalls the upstream pipeline while a bus transaction is outstanding and feeds the WB pipeline register.

---
 rtl/memory_access_unit.sv | 277 +++++++++++++++++++++++++++
 tb/tb_memory_access_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_unit.sv
// Load/store stage that talks to a variable-latency request/ack bus.
// Line-crossing accesses become two bus beats, or a trap when ALLOW_MISALIGNED=0.
module memory_access_unit #(
    parameter int NB_REG           = 32,
    parameter int NB_ADDR          = 32,
    parameter int NB_MEM           = 5,
    parameter int NB_WB            = 8,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_valid,
    output logic                  o_stall,
    input  logic [NB_ADDR-1:0]    i_alu_o,
    input  logic [NB_REG-1:0]     i_b_o,
    input  logic [NB_MEM-1:0]     i_mem,
    input  logic [NB_WB-1:0]      i_wb,
    input  logic [NB_REG-1:0]     i_pc,
    output logic                  o_bus_req,
    output logic                  o_bus_we,
    output logic [NB_ADDR-1:0]    o_bus_addr,
    output logic [NB_REG/8-1:0]   o_bus_be,
    output logic [NB_REG-1:0]     o_bus_wdata,
    input  logic                  i_bus_ack,
    input  logic [NB_REG-1:0]     i_bus_rdata,
    output logic                  o_valid,
    output logic [NB_REG-1:0]     o_reg_wb,
    output logic [NB_REG-1:0]     o_ext_mem_o,
    output logic [NB_WB-1:0]      o_wb,
    output logic [NB_REG-1:0]     o_pc,
    output logic                  o_misalign
);
    localparam int NB_BYTES = NB_REG / 8;
    localparam int OFF_W    = $clog2(NB_BYTES);
    localparam int BW       = OFF_W + 1;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

    state_t              state_q, state_d;
    logic                gap_q, gap_d;
    logic [NB_ADDR-1:0]  addr_q, addr_d;
    logic [NB_REG-1:0]   data_q, data_d;
    logic                store_q, store_d;
    logic                s_u_q, s_u_d;
    logic [1:0]          dsize_q, dsize_d;
    logic [NB_WB-1:0]    wb_q, wb_d;
    logic [NB_REG-1:0]   pc_q, pc_d;
    logic [NB_REG-1:0]   rdata0_q, rdata0_d;
    logic [NB_REG-1:0]   rdata1_q, rdata1_d;

    logic                valid_q, valid_d;
    logic [NB_REG-1:0]   reg_wb_q, reg_wb_d;
    logic [NB_REG-1:0]   ext_q, ext_d;
    logic [NB_WB-1:0]    wb_out_q, wb_out_d;
    logic [NB_REG-1:0]   pc_out_q, pc_out_d;
    logic                misalign_q, misalign_d;

    logic                in_re, in_we, in_s_u, in_mem_op;
    logic [1:0]          in_dsize;
    logic [NB_ADDR-1:0]  src_addr;
    logic [1:0]          src_dsize;
    logic [OFF_W-1:0]    off;
    logic [NB_ADDR-1:0]  line_addr;
    logic [BW-1:0]       size_bytes;
    logic                crossing;
    logic [2*NB_BYTES-1:0] be_wide;
    logic [2*NB_REG-1:0] wdata_wide;
    logic [NB_REG-1:0]   load_raw;
    logic [NB_REG-1:0]   load_ext;
    logic                sign_bit, fill_bit;
    logic [NB_REG-1:0]   alu_in_ext, alu_q_ext;
    logic                stall_c, bus_req_c;

    assign in_re     = i_mem[4];
    assign in_we     = i_mem[3];
    assign in_s_u    = i_mem[2];
    assign in_dsize  = i_mem[1:0];
    assign in_mem_op = in_re | in_we;

    // Decode the live inputs while idle, the latched op once a transaction is in flight.
    assign src_addr  = (state_q == IDLE) ? i_alu_o  : addr_q;
    assign src_dsize = (state_q == IDLE) ? in_dsize : dsize_q;
    assign off       = src_addr[OFF_W-1:0];
    assign line_addr = {src_addr[NB_ADDR-1:OFF_W], {OFF_W{1'b0}}};

    always_comb begin
        if (int'(src_dsize) > OFF_W) begin
            size_bytes = BW'(NB_BYTES);
        end else begin
            size_bytes = BW'(1) << src_dsize;
        end
    end

    assign crossing = (BW'(off) + size_bytes) > BW'(NB_BYTES);

    // Two-line-wide views: the low half is beat 0, the spill-over is beat 1.
    assign be_wide    = (((2*NB_BYTES)'(1) << size_bytes) - (2*NB_BYTES)'(1)) << off;
    assign wdata_wide = {{NB_REG{1'b0}}, data_q} << {off, 3'b000};
    assign load_raw   = NB_REG'({rdata1_q, rdata0_q} >> {off, 3'b000});

    always_comb begin
        sign_bit = 1'b0;
        for (int i = 0; i < NB_BYTES; i++) begin
            if (BW'(i + 1) == size_bytes) begin
                sign_bit = load_raw[8*i+7];
            end
        end
    end

    assign fill_bit = ~s_u_q & sign_bit;

    genvar gi;
    generate
        for (gi = 0; gi < NB_BYTES; gi++) begin : g_ext
            assign load_ext[8*gi +: 8] = (BW'(gi) < size_bytes) ? load_raw[8*gi +: 8] : {8{fill_bit}};
        end

        if (NB_ADDR >= NB_REG) begin : g_alu_trunc
            assign alu_in_ext = i_alu_o[NB_REG-1:0];
            assign alu_q_ext  = addr_q[NB_REG-1:0];
        end else begin : g_alu_zext
            assign alu_in_ext = {{(NB_REG-NB_ADDR){1'b0}}, i_alu_o};
            assign alu_q_ext  = {{(NB_REG-NB_ADDR){1'b0}}, addr_q};
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        addr_d     = addr_q;
        data_d     = data_q;
        store_d    = store_q;
        s_u_d      = s_u_q;
        dsize_d    = dsize_q;
        wb_d       = wb_q;
        pc_d       = pc_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        valid_d    = 1'b0;
        reg_wb_d   = reg_wb_q;
        ext_d      = ext_q;
        wb_out_d   = wb_out_q;
        pc_out_d   = pc_out_q;
        misalign_d = misalign_q;
        stall_c    = 1'b0;
        bus_req_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    if (!in_mem_op) begin
                        valid_d    = 1'b1;
                        reg_wb_d   = alu_in_ext;
                        ext_d      = '0;
                        wb_out_d   = i_wb;
                        pc_out_d   = i_pc;
                        misalign_d = 1'b0;
                    end else if (crossing && !ALLOW_MISALIGNED) begin
                        // Trap: writeback is squashed and the bus is never touched.
                        valid_d    = 1'b1;
                        reg_wb_d   = alu_in_ext;
                        ext_d      = '0;
                        wb_out_d   = '0;
                        pc_out_d   = i_pc;
                        misalign_d = 1'b1;
                    end else begin
                        stall_c  = 1'b1;
                        addr_d   = i_alu_o;
                        data_d   = i_b_o;
                        store_d  = in_we;
                        s_u_d    = in_s_u;
                        dsize_d  = in_dsize;
                        wb_d     = i_wb;
                        pc_d     = i_pc;
                        rdata0_d = '0;
                        rdata1_d = '0;
                        gap_d    = 1'b0;
                        state_d  = BEAT0;
                    end
                end
            end
            BEAT0: begin
                stall_c   = 1'b1;
                bus_req_c = 1'b1;
                if (i_bus_ack) begin
                    rdata0_d = i_bus_rdata;
                    if (crossing) begin
                        state_d = BEAT1;
                        gap_d   = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            BEAT1: begin
                stall_c = 1'b1;
                // One idle bus cycle separates the two beats.
                if (gap_q) begin
                    gap_d = 1'b0;
                end else begin
                    bus_req_c = 1'b1;
                    if (i_bus_ack) begin
                        rdata1_d = i_bus_rdata;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                valid_d    = 1'b1;
                reg_wb_d   = alu_q_ext;
                ext_d      = store_q ? '0 : load_ext;
                wb_out_d   = wb_q;
                pc_out_d   = pc_q;
                misalign_d = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            gap_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            store_q    <= 1'b0;
            s_u_q      <= 1'b0;
            dsize_q    <= '0;
            wb_q       <= '0;
            pc_q       <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            valid_q    <= 1'b0;
            reg_wb_q   <= '0;
            ext_q      <= '0;
            wb_out_q   <= '0;
            pc_out_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            store_q    <= store_d;
            s_u_q      <= s_u_d;
            dsize_q    <= dsize_d;
            wb_q       <= wb_d;
            pc_q       <= pc_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            valid_q    <= valid_d;
            reg_wb_q   <= reg_wb_d;
            ext_q      <= ext_d;
            wb_out_q   <= wb_out_d;
            pc_out_q   <= pc_out_d;
            misalign_q <= misalign_d;
        end
    end

    assign o_stall     = i_reset & stall_c;
    assign o_bus_req   = bus_req_c;
    assign o_bus_we    = bus_req_c & store_q;
    assign o_bus_addr  = !bus_req_c ? '0 :
                         (state_q == BEAT1) ? line_addr + NB_ADDR'(NB_BYTES) : line_addr;
    assign o_bus_be    = !bus_req_c ? '0 :
                         (state_q == BEAT1) ? be_wide[2*NB_BYTES-1:NB_BYTES] : be_wide[NB_BYTES-1:0];
    assign o_bus_wdata = !bus_req_c ? '0 :
                         (state_q == BEAT1) ? wdata_wide[2*NB_REG-1:NB_REG] : wdata_wide[NB_REG-1:0];

    assign o_valid     = valid_q;
    assign o_reg_wb    = reg_wb_q;
    assign o_ext_mem_o = ext_q;
    assign o_wb        = wb_out_q;
    assign o_pc        = pc_out_q;
    assign o_misalign  = misalign_q;
endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: two 32-bit instances (split / trap) and one 64-bit instance.
`timescale 1ns/1ps
module tb_memory_access_unit;
    typedef struct {
        int          dut;
        logic [63:0] reg_wb;
        logic [63:0] ext;
        logic [63:0] pc;
        logic [7:0]  wb;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    int          total_cnt = 0;
    int          pass_cnt = 0;
    int          fail_cnt = 0;
    exp_t        sb[$];

    logic        vin [3];
    logic        ack [3];
    logic [31:0] alu;
    logic [63:0] bdat;
    logic [63:0] pc;
    logic [63:0] rdata;
    logic [4:0]  mem;
    logic [7:0]  wb;

    logic        stall_o [3];
    logic        req_o [3];
    logic        we_o [3];
    logic        valid_o [3];
    logic        mis_o [3];
    logic [31:0] addr_o [3];
    logic [7:0]  be_o [3];
    logic [7:0]  wbo_o [3];
    logic [63:0] wdata_o [3];
    logic [63:0] regwb_o [3];
    logic [63:0] ext_o [3];
    logic [63:0] pc_o [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0 splits line-crossing accesses, instance 1 traps them.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g32
            logic [3:0]  be;
            logic [31:0] wdata, reg_wb, ext, pc_w;
            memory_access_unit #(
                .NB_REG(32), .NB_ADDR(32), .NB_MEM(5), .NB_WB(8),
                .ALLOW_MISALIGNED(gi == 0)
            ) u_dut (
                .i_clock(clk), .i_reset(rst_n), .i_valid(vin[gi]), .o_stall(stall_o[gi]),
                .i_alu_o(alu), .i_b_o(bdat[31:0]), .i_mem(mem), .i_wb(wb), .i_pc(pc[31:0]),
                .o_bus_req(req_o[gi]), .o_bus_we(we_o[gi]), .o_bus_addr(addr_o[gi]),
                .o_bus_be(be), .o_bus_wdata(wdata), .i_bus_ack(ack[gi]),
                .i_bus_rdata(rdata[31:0]), .o_valid(valid_o[gi]), .o_reg_wb(reg_wb),
                .o_ext_mem_o(ext), .o_wb(wbo_o[gi]), .o_pc(pc_w), .o_misalign(mis_o[gi])
            );
            assign be_o[gi]    = {4'b0, be};
            assign wdata_o[gi] = {32'b0, wdata};
            assign regwb_o[gi] = {32'b0, reg_wb};
            assign ext_o[gi]   = {32'b0, ext};
            assign pc_o[gi]    = {32'b0, pc_w};
        end
    endgenerate

    memory_access_unit #(
        .NB_REG(64), .NB_ADDR(32), .NB_MEM(5), .NB_WB(8), .ALLOW_MISALIGNED(1'b1)
    ) u_dut64 (
        .i_clock(clk), .i_reset(rst_n), .i_valid(vin[2]), .o_stall(stall_o[2]),
        .i_alu_o(alu), .i_b_o(bdat), .i_mem(mem), .i_wb(wb), .i_pc(pc),
        .o_bus_req(req_o[2]), .o_bus_we(we_o[2]), .o_bus_addr(addr_o[2]),
        .o_bus_be(be_o[2]), .o_bus_wdata(wdata_o[2]), .i_bus_ack(ack[2]),
        .i_bus_rdata(rdata), .o_valid(valid_o[2]), .o_reg_wb(regwb_o[2]),
        .o_ext_mem_o(ext_o[2]), .o_wb(wbo_o[2]), .o_pc(pc_o[2]), .o_misalign(mis_o[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int d, input logic [31:0] a, input logic [63:0] b, input logic [4:0] m,
                         input logic [7:0] w, input logic [63:0] p, input logic [63:0] e_ext,
                         input logic mis, input bit track);
        exp_t e;
        alu = a; bdat = b; mem = m; wb = w; pc = p;
        vin[d] = 1'b1;
        if (track) begin
            e.dut = d; e.reg_wb = {32'b0, a}; e.ext = e_ext; e.pc = p;
            e.wb = mis ? 8'h00 : w; e.mis = mis;
            sb.push_back(e);
        end
        #1;
    endtask

    // Called in a cycle where the DUT should be requesting; acks after 'waits' idle cycles.
    task automatic beat(input int d, input string tag, input int waits, input logic [63:0] rd,
                        input logic [31:0] ea, input logic [7:0] ebe, input logic [63:0] ewd,
                        input logic ewe);
        check({tag, " req"},   64'(req_o[d]), 64'd1);
        check({tag, " addr"},  64'(addr_o[d]), 64'(ea));
        check({tag, " be"},    64'(be_o[d]), 64'(ebe));
        check({tag, " wdata"}, wdata_o[d], ewd);
        check({tag, " we"},    64'(we_o[d]), 64'(ewe));
        repeat (waits) tick();
        check({tag, " addr held"}, 64'(addr_o[d]), 64'(ea));
        ack[d] = 1'b1;
        rdata = rd;
        tick();
        ack[d] = 1'b0;
        rdata = '0;
        #1;
    endtask

    task automatic wait_out(input string tag, output int seen_cyc);
        exp_t e;
        int   n;
        e = sb.pop_front();
        n = 0;
        while (valid_o[e.dut] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        seen_cyc = cyc;
        check({tag, " o_valid"},    64'(valid_o[e.dut]), 64'd1);
        check({tag, " o_reg_wb"},   regwb_o[e.dut], e.reg_wb);
        check({tag, " o_ext_mem_o"}, ext_o[e.dut], e.ext);
        check({tag, " o_wb"},       64'(wbo_o[e.dut]), 64'(e.wb));
        check({tag, " o_pc"},       pc_o[e.dut], e.pc);
        check({tag, " o_misalign"}, 64'(mis_o[e.dut]), 64'(e.mis));
        $display("txn %s dut=%0d reg_wb=%h ext=%h wb=%h pc=%h misalign=%b",
                 tag, e.dut, regwb_o[e.dut], ext_o[e.dut], wbo_o[e.dut], pc_o[e.dut], mis_o[e.dut]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int seen;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vin[i] = 1'b0;
            ack[i] = 1'b0;
        end
        alu = '0; bdat = '0; mem = '0; wb = '0; pc = '0; rdata = '0;
        tick();
        tick();
        check("reset o_valid",  64'(valid_o[0]), 64'd0);
        check("reset o_reg_wb", regwb_o[0], 64'd0);
        check("reset o_bus_req", 64'(req_o[0]), 64'd0);
        check("reset o_stall",  64'(stall_o[0]), 64'd0);
        check("reset ext64",    ext_o[2], 64'd0);
        rst_n = 1'b1;
        tick();

        // lb 0x1003, sign-extended, ack after 3 wait cycles
        issue(0, 32'h1003, 64'd0, 5'b10000, 8'hA5, 64'h100, 64'hFFFF_FF80, 1'b0, 1'b1);
        check("lb stall accept", 64'(stall_o[0]), 64'd1);
        check("lb no req accept", 64'(req_o[0]), 64'd0);
        tick();
        acc = cyc;
        beat(0, "lb", 3, 64'h80FF_0000, 32'h1000, 8'h08, 64'd0, 1'b0);
        check("lb req drop", 64'(req_o[0]), 64'd0);
        check("lb stall done", 64'(stall_o[0]), 64'd0);
        vin[0] = 1'b0;
        wait_out("lb", seen);
        check("lb latency", 64'(seen - acc), 64'd5);
        tick();
        check("lb valid pulse", 64'(valid_o[0]), 64'd0);

        // sh 0x2002
        issue(0, 32'h2002, 64'h0000_ABCD, 5'b01001, 8'h3C, 64'h104, 64'd0, 1'b0, 1'b1);
        tick();
        beat(0, "sh", 0, 64'hDEAD_BEEF, 32'h2000, 8'h0C, 64'hABCD_0000, 1'b1);
        vin[0] = 1'b0;
        wait_out("sh", seen);

        // dsize=11 on 32-bit behaves as a full word
        issue(0, 32'h4000, 64'd0, 5'b10011, 8'h21, 64'h108, 64'h89AB_CDEF, 1'b0, 1'b1);
        tick();
        beat(0, "ld32", 1, 64'h89AB_CDEF, 32'h4000, 8'h0F, 64'd0, 1'b0);
        vin[0] = 1'b0;
        wait_out("ld32", seen);

        // misaligned sw 0x3003, two beats
        issue(0, 32'h3003, 64'h1122_3344, 5'b01010, 8'h42, 64'h10C, 64'd0, 1'b0, 1'b1);
        tick();
        beat(0, "sw b0", 0, 64'd0, 32'h3000, 8'h08, 64'h4400_0000, 1'b1);
        check("sw gap req", 64'(req_o[0]), 64'd0);
        tick();
        beat(0, "sw b1", 0, 64'd0, 32'h3004, 8'h07, 64'h0011_2233, 1'b1);
        vin[0] = 1'b0;
        wait_out("sw mis", seen);

        // misaligned lw 0x3003, two beats
        issue(0, 32'h3003, 64'd0, 5'b10010, 8'h55, 64'h110, 64'h1122_3344, 1'b0, 1'b1);
        tick();
        beat(0, "lw b0", 2, 64'h4400_0000, 32'h3000, 8'h08, 64'd0, 1'b0);
        check("lw gap req", 64'(req_o[0]), 64'd0);
        check("lw gap stall", 64'(stall_o[0]), 64'd1);
        tick();
        beat(0, "lw b1", 1, 64'h0011_2233, 32'h3004, 8'h07, 64'd0, 1'b0);
        vin[0] = 1'b0;
        wait_out("lw mis", seen);

        // same access trapped
        issue(1, 32'h3003, 64'd0, 5'b10010, 8'h77, 64'h300, 64'd0, 1'b1, 1'b1);
        check("trap stall", 64'(stall_o[1]), 64'd0);
        check("trap no req", 64'(req_o[1]), 64'd0);
        acc = cyc;
        wait_out("lw trap", seen);
        vin[1] = 1'b0;
        check("trap latency", 64'(seen - acc), 64'd1);
        check("trap no req after", 64'(req_o[1]), 64'd0);

        // 64-bit ld, lwu, lw
        issue(2, 32'h10, 64'd0, 5'b10011, 8'h11, 64'h200, 64'h8000_0000_0000_0001, 1'b0, 1'b1);
        tick();
        beat(2, "ld64", 0, 64'h8000_0000_0000_0001, 32'h10, 8'hFF, 64'd0, 1'b0);
        vin[2] = 1'b0;
        wait_out("ld64", seen);
        issue(2, 32'h14, 64'd0, 5'b10110, 8'h12, 64'h204, 64'h0000_0000_8000_0000, 1'b0, 1'b1);
        tick();
        beat(2, "lwu64", 0, 64'h8000_0000_0000_0001, 32'h10, 8'hF0, 64'd0, 1'b0);
        vin[2] = 1'b0;
        wait_out("lwu64", seen);
        issue(2, 32'h14, 64'd0, 5'b10010, 8'h13, 64'h208, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1);
        tick();
        beat(2, "lw64", 0, 64'h8000_0000_0000_0001, 32'h10, 8'hF0, 64'd0, 1'b0);
        vin[2] = 1'b0;
        wait_out("lw64", seen);

        // reset while BEAT1 waits for ack
        issue(0, 32'h3003, 64'd0, 5'b10010, 8'h99, 64'h500, 64'd0, 1'b0, 1'b0);
        tick();
        beat(0, "rst b0", 0, 64'h4400_0000, 32'h3000, 8'h08, 64'd0, 1'b0);
        tick();
        check("rst beat1 req", 64'(req_o[0]), 64'd1);
        vin[0] = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("rst req async", 64'(req_o[0]), 64'd0);
        check("rst stall", 64'(stall_o[0]), 64'd0);
        check("rst reg_wb", regwb_o[0], 64'd0);
        check("rst ext", ext_o[0], 64'd0);
        check("rst wb", 64'(wbo_o[0]), 64'd0);
        check("rst pc", pc_o[0], 64'd0);
        tick();
        rst_n = 1'b1;
        ack[0] = 1'b1;
        rdata = 64'h0011_2233;
        tick();
        ack[0] = 1'b0;
        rdata = '0;
        #1;
        check("late ack req", 64'(req_o[0]), 64'd0);
        check("late ack valid", 64'(valid_o[0]), 64'd0);
        tick();
        check("late ack valid2", 64'(valid_o[0]), 64'd0);

        // ALU-only pass-through
        issue(0, 32'h1234_5678, 64'd0, 5'b00000, 8'h5A, 64'h400, 64'd0, 1'b0, 1'b1);
        check("alu stall", 64'(stall_o[0]), 64'd0);
        acc = cyc;
        wait_out("alu", seen);
        vin[0] = 1'b0;
        check("alu latency", 64'(seen - acc), 64'd1);
        tick();
        check("alu valid pulse", 64'(valid_o[0]), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
